div_pipe_8bit: RTL and testbench



---
 rtl/div_pipe_8bit.sv | 107 ++++++++++
 tb/tb_div_pipe_8bit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_pipe_8bit.sv
// Fully pipelined unsigned restoring divider: 2*size-bit dividend / size-bit divisor, one op per cycle.
// Optional macro DIV_PIPE_ZERO_FLAG_EN exposes the divide-by-zero flag on port div_zero.
module div_pipe_8bit #(
  parameter int size = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*size-1:0]   div_a,
  input  logic [size-1:0]     div_b,
  input  logic                div_en_in,
  output logic                div_en_out,
  output logic [2*size-1:0]   div_q,
  output logic [size-1:0]     div_r
`ifdef DIV_PIPE_ZERO_FLAG_EN
  ,
  output logic                div_zero
`endif
);

  localparam int N    = 2 * size;
  localparam int LAST = N + 1;

  logic [N-1:0]    dvd_r   [0:LAST];
  logic [size-1:0] dvs_r   [0:LAST];
  logic [size-1:0] rem_r   [0:LAST];
  logic [N-1:0]    quo_r   [0:LAST];
  logic [size-1:0] low_r   [0:LAST];
  logic            zero_r  [0:LAST];
  logic            valid_r [0:LAST];

  logic [size:0]   trial    [2:LAST];
  logic [size:0]   diff     [2:LAST];
  logic            ge       [2:LAST];
  logic [size-1:0] next_rem [2:LAST];

  // One restoring step per stage: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    for (int s = 2; s <= LAST; s++) begin
      trial[s]    = {rem_r[s-1], dvd_r[s-1][N-1]};
      diff[s]     = trial[s] - {1'b0, dvs_r[s-1]};
      ge[s]       = (trial[s] >= {1'b0, dvs_r[s-1]});
      next_rem[s] = ge[s] ? diff[s][size-1:0] : trial[s][size-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s <= LAST; s++) begin
        dvd_r[s]   <= '0;
        dvs_r[s]   <= '0;
        rem_r[s]   <= '0;
        quo_r[s]   <= '0;
        low_r[s]   <= '0;
        zero_r[s]  <= 1'b0;
        valid_r[s] <= 1'b0;
      end
      div_en_out <= 1'b0;
      div_q      <= '0;
      div_r      <= '0;
`ifdef DIV_PIPE_ZERO_FLAG_EN
      div_zero   <= 1'b0;
`endif
    end else begin
      valid_r[0] <= div_en_in;
      dvd_r[0]   <= div_en_in ? div_a : '0;
      dvs_r[0]   <= div_en_in ? div_b : '0;
      low_r[0]   <= div_en_in ? div_a[size-1:0] : '0;
      zero_r[0]  <= div_en_in && (div_b == '0);
      rem_r[0]   <= '0;
      quo_r[0]   <= '0;

      // Alignment stage: keeps total latency at 2*size+2 to match the multiplier path.
      valid_r[1] <= valid_r[0];
      dvd_r[1]   <= dvd_r[0];
      dvs_r[1]   <= dvs_r[0];
      low_r[1]   <= low_r[0];
      zero_r[1]  <= zero_r[0];
      rem_r[1]   <= '0;
      quo_r[1]   <= '0;

      for (int s = 2; s <= LAST; s++) begin
        valid_r[s] <= valid_r[s-1];
        dvd_r[s]   <= {dvd_r[s-1][N-2:0], 1'b0};
        dvs_r[s]   <= dvs_r[s-1];
        low_r[s]   <= low_r[s-1];
        zero_r[s]  <= zero_r[s-1];
        rem_r[s]   <= next_rem[s];
        quo_r[s]   <= {quo_r[s-1][N-2:0], ge[s]};
      end

      // Divide-by-zero overrides the arithmetic with all-ones and the low dividend byte.
      if (valid_r[LAST]) begin
        div_en_out <= 1'b1;
        div_q      <= zero_r[LAST] ? {N{1'b1}} : quo_r[LAST];
        div_r      <= zero_r[LAST] ? low_r[LAST] : rem_r[LAST];
      end else begin
        div_en_out <= 1'b0;
        div_q      <= '0;
        div_r      <= '0;
      end
`ifdef DIV_PIPE_ZERO_FLAG_EN
      div_zero   <= valid_r[LAST] && zero_r[LAST];
`endif
    end
  end

endmodule

// File: tb/tb_div_pipe_8bit.sv
// Self-checking bench for div_pipe_8bit: directed cases from the test plan plus a randomized stream
// checked against an arithmetic (/ and %) reference delayed by the 18-cycle pipeline latency.
module tb_div_pipe_8bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] div_a = '0;
  logic [7:0]  div_b = '0;
  logic        div_en_in = 1'b0;
  logic        div_en_out;
  logic [15:0] div_q;
  logic [7:0]  div_r;
  logic        zero_obs;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        en;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } res_t;

  res_t obs;

`ifdef DIV_PIPE_ZERO_FLAG_EN
  localparam bit ZF = 1'b1;
  logic div_zero;
  assign zero_obs = div_zero;
`else
  localparam bit ZF = 1'b0;
  assign zero_obs = 1'b0;
`endif

  assign obs = {div_en_out, div_q, div_r, zero_obs};

  div_pipe_8bit #(.size(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_en_in  (div_en_in),
    .div_en_out (div_en_out),
    .div_q      (div_q),
    .div_r      (div_r)
`ifdef DIV_PIPE_ZERO_FLAG_EN
    ,
    .div_zero   (div_zero)
`endif
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic en, input logic [15:0] a, input logic [7:0] b);
    res_t m;
    m = '0;
    if (en) begin
      m.en = 1'b1;
      if (b == 8'd0) begin
        m.q = 16'hFFFF;
        m.r = a[7:0];
        m.z = ZF;
      end else begin
        m.q = a / {8'd0, b};
        m.r = 8'(a % {8'd0, b});
      end
    end
    return m;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (obs !== res_t'(0)) begin
        bad++;
        $display("[TB] FAIL reset_idle i=%0d got en=%0b q=%h r=%h z=%0b want all zero",
                 i, obs.en, obs.q, obs.r, obs.z);
      end
    end
  endtask

  task automatic test_single;
    res_t e;
    @(negedge clk);
    div_a = 16'd1000; div_b = 8'd7; div_en_in = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      e = (i == 18) ? res_t'{en: 1'b1, q: 16'd142, r: 8'd6, z: 1'b0} : res_t'(0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("[TB] FAIL single i=%0d got en=%0b q=%h r=%h z=%0b want en=%0b q=%h r=%h z=%0b",
                 i, obs.en, obs.q, obs.r, obs.z, e.en, e.q, e.r, e.z);
      end
      if (i == 0) div_en_in = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] as [4] = '{16'hFFFF, 16'd5, 16'h1234, 16'd255};
    logic [7:0]  bs [4] = '{8'd255, 8'd10, 8'h12, 8'd1};
    logic [15:0] qs [4] = '{16'd257, 16'd0, 16'h0102, 16'd255};
    logic [7:0]  rs [4] = '{8'd0, 8'd5, 8'h10, 8'd0};
    res_t e;
    @(negedge clk);
    div_a = as[0]; div_b = bs[0]; div_en_in = 1'b1;
    for (int i = 0; i <= 23; i++) begin
      @(negedge clk);
      e = '0;
      if (i >= 18 && i <= 21) e = res_t'{en: 1'b1, q: qs[i-18], r: rs[i-18], z: 1'b0};
      total++;
      if (obs !== e) begin
        bad++;
        $display("[TB] FAIL back_to_back i=%0d got en=%0b q=%h r=%h z=%0b want en=%0b q=%h r=%h z=%0b",
                 i, obs.en, obs.q, obs.r, obs.z, e.en, e.q, e.r, e.z);
      end
      if (i < 3) begin
        div_a = as[i+1]; div_b = bs[i+1];
      end else begin
        div_en_in = 1'b0;
      end
    end
  endtask

  task automatic test_div_zero;
    res_t e;
    @(negedge clk);
    div_a = 16'd200; div_b = 8'd0; div_en_in = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      e = (i == 18) ? res_t'{en: 1'b1, q: 16'hFFFF, r: 8'hC8, z: ZF} : res_t'(0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("[TB] FAIL div_zero i=%0d got en=%0b q=%h r=%h z=%0b want en=%0b q=%h r=%h z=%0b",
                 i, obs.en, obs.q, obs.r, obs.z, e.en, e.q, e.r, e.z);
      end
      if (i == 0) div_en_in = 1'b0;
    end
  endtask

  task automatic test_disabled;
    @(negedge clk);
    div_a = 16'hFFFF; div_b = 8'd3; div_en_in = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      total++;
      if (obs !== res_t'(0)) begin
        bad++;
        $display("[TB] FAIL disabled i=%0d got en=%0b q=%h r=%h z=%0b want all zero",
                 i, obs.en, obs.q, obs.r, obs.z);
      end
    end
  endtask

  task automatic test_reset_midflight;
    res_t e;
    @(negedge clk);
    div_a = 16'd500; div_b = 8'd7; div_en_in = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      e = (i == 31) ? res_t'{en: 1'b1, q: 16'd11, r: 8'd1, z: 1'b0} : res_t'(0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("[TB] FAIL reset_midflight i=%0d got en=%0b q=%h r=%h z=%0b want en=%0b q=%h r=%h z=%0b",
                 i, obs.en, obs.q, obs.r, obs.z, e.en, e.q, e.r, e.z);
      end
      if (i == 0) div_en_in = 1'b0;
      if (i == 8) rst = 1'b1;
      if (i == 9) rst = 1'b0;
      if (i == 12) begin
        div_a = 16'd100; div_b = 8'd9; div_en_in = 1'b1;
      end
      if (i == 13) div_en_in = 1'b0;
    end
  endtask

  task automatic test_random;
    res_t exp_q [$];
    res_t e;
    logic en;
    logic [15:0] a;
    logic [7:0] b;
    for (int i = 0; i < 19; i++) exp_q.push_back('0);
    for (int t = 0; t < 319; t++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("[TB] FAIL random t=%0d got en=%0b q=%h r=%h z=%0b want en=%0b q=%h r=%h z=%0b",
                 t, obs.en, obs.q, obs.r, obs.z, e.en, e.q, e.r, e.z);
      end
      en = (t < 300) && ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       b = 8'd0;
        1:       b = 8'($urandom_range(1, 3));
        default: b = 8'($urandom);
      endcase
      a = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
      div_a = a; div_b = b; div_en_in = en;
      exp_q.push_back(model(en, a, b));
    end
    div_en_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_div_zero();
    test_disabled();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
